// File: rtl/layer0_input_packer.sv
// Layer-0 input packer: quantizes a stream of signed features and packs NUM_FEAT of them into one registered vector.
// Optional feature: define LAYER0_PACK_ROUND_EN for round-half-up quantization instead of floor.
module layer0_input_packer #(
  parameter int NUM_FEAT = 16,
  parameter int IN_W     = 16,
  parameter int Q_BITS   = 2,
  parameter int SHIFT    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [IN_W-1:0]              s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_FEAT*Q_BITS-1:0]   m_data,
  output logic                         err_len
);

  localparam int IDX_W = $clog2(NUM_FEAT);
  localparam int ASM_W = (NUM_FEAT - 1) * Q_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam int QMAX = (1 << (Q_BITS - 1)) - 1;
  localparam int QMIN = -(1 << (Q_BITS - 1));
  localparam logic signed [IN_W:0] QMAX_W = (IN_W + 1)'(QMAX);
  localparam logic signed [IN_W:0] QMIN_W = (IN_W + 1)'(QMIN);

  logic [IDX_W-1:0]        idx;
  logic [ASM_W-1:0]        asm_q;
  logic signed [IN_W:0]    pre_shift;
  logic signed [IN_W:0]    shifted;
  logic [Q_BITS-1:0]       q;
  logic                    in_last;
  logic                    accept;

  // One extra bit of headroom keeps the rounding add from wrapping at the top of the range.
`ifdef LAYER0_PACK_ROUND_EN
  localparam logic signed [IN_W:0] HALF_LSB = (IN_W + 1)'(1 << (SHIFT - 1));
  assign pre_shift = $signed({s_data[IN_W-1], s_data}) + HALF_LSB;
`else
  assign pre_shift = $signed({s_data[IN_W-1], s_data});
`endif

  assign shifted = pre_shift >>> SHIFT;

  always_comb begin
    q = shifted[Q_BITS-1:0];
    if (shifted > QMAX_W) begin
      q = QMAX_W[Q_BITS-1:0];
    end else if (shifted < QMIN_W) begin
      q = QMIN_W[Q_BITS-1:0];
    end
  end

  assign in_last = (idx == LAST_IDX);
  assign accept  = s_valid && s_ready;

  // Only the final slot can stall: it needs the output register free or being drained.
  always_comb begin
    s_ready = 1'b0;
    if (rst_n) begin
      s_ready = in_last ? (!m_valid || m_ready) : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      asm_q   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      err_len <= 1'b0;
    end else begin
      err_len <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept) begin
        if (in_last) begin
          m_data  <= {q, asm_q};
          m_valid <= 1'b1;
          idx     <= '0;
          err_len <= !s_last;
        end else if (s_last) begin
          // Short sample: drop the partial assembly and resynchronize on the next beat.
          idx     <= '0;
          err_len <= 1'b1;
        end else begin
          asm_q[idx*Q_BITS +: Q_BITS] <= q;
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer0_input_packer.sv
// Scoreboard bench for layer0_input_packer with NUM_FEAT=3, IN_W=8, Q_BITS=2, SHIFT=4.
module tb_layer0_input_packer;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [5:0] m_data;
  logic       err_len;

  int n_checks = 0;
  int n_fail   = 0;
  int out_seen = 0;
  int err_seen = 0;
  int exp_err  = 0;

  logic [5:0] exp_q[$];
  int         model_idx = 0;
  logic [1:0] slot0 = 2'b00;
  logic [1:0] slot1 = 2'b00;

  layer0_input_packer #(
    .NUM_FEAT(3),
    .IN_W    (8),
    .Q_BITS  (2),
    .SHIFT   (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [1:0] quant(input logic [7:0] d);
    int v;
    v = $signed(d);
`ifdef LAYER0_PACK_ROUND_EN
    v = v + 8;
`endif
    v = v >>> 4;
    if (v > 1) v = 1;
    if (v < -2) v = -2;
    return v[1:0];
  endfunction

  task automatic model_accept(input logic [7:0] d, input logic last);
    logic [1:0] q;
    q = quant(d);
    if (model_idx == 2) begin
      exp_q.push_back({q, slot1, slot0});
      if (!last) exp_err++;
      model_idx = 0;
    end else if (last) begin
      exp_err++;
      model_idx = 0;
    end else begin
      if (model_idx == 0) slot0 = q;
      else slot1 = q;
      model_idx++;
    end
  endtask

  task automatic model_reset();
    model_idx = 0;
    slot0 = 2'b00;
    slot1 = 2'b00;
  endtask

  // Scoreboard: every consumed sample is compared against the model queue.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      n_checks++;
      out_seen++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_sample: m_data=%b, required no output", m_data);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_fail++;
          $display("[TB] FAIL sample_data: m_data=%b, required %b", m_data, e);
        end
      end
    end
    if (err_len === 1'b1) err_seen++;
  end

  task automatic send_beat(input logic [7:0] d, input logic last, output int stalls);
    int waited;
    logic accepted;
    waited = 0;
    stalls = 0;
    accepted = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        accepted = 1'b1;
        break;
      end
      stalls++;
      waited++;
      if (waited > 50) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL beat_timeout: s_ready=%b after %0d cycles, required 1", s_ready, waited);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (accepted) model_accept(d, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_s_ready: got %b, required 0", s_ready); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_valid: got %b, required 0", m_valid); end
    n_checks++;
    if (m_data !== 6'b000000) begin n_fail++; $display("[TB] FAIL reset_m_data: got %b, required 000000", m_data); end
    n_checks++;
    if (err_len !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err_len: got %b, required 0", err_len); end
    rst_n = 1'b1;
    model_reset();
    idle(1);
  endtask

  task automatic test_basic();
    int st;
    m_ready = 1'b1;
    send_beat(8'h10, 1'b0, st);
    send_beat(8'hE0, 1'b0, st);
    send_beat(8'h7F, 1'b1, st);
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b, required 1", m_valid); end
    n_checks++;
    if (m_data !== 6'b011001) begin n_fail++; $display("[TB] FAIL basic_data: got %b, required 011001", m_data); end
    idle(1);
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_one_cycle: m_valid=%b, required 0", m_valid); end
  endtask

  task automatic test_rounding();
    int st;
    logic [5:0] req;
`ifdef LAYER0_PACK_ROUND_EN
    req = 6'b010101;
`else
    req = 6'b000000;
`endif
    m_ready = 1'b1;
    send_beat(8'h08, 1'b0, st);
    send_beat(8'h08, 1'b0, st);
    send_beat(8'h08, 1'b1, st);
    n_checks++;
    if (m_data !== req) begin n_fail++; $display("[TB] FAIL rounding_data: got %b, required %b", m_data, req); end
    idle(1);
  endtask

  task automatic test_backpressure();
    int st;
    m_ready = 1'b0;
    send_beat(8'h00, 1'b0, st);
    send_beat(8'h10, 1'b0, st);
    send_beat(8'hE0, 1'b1, st);
    send_beat(8'hF0, 1'b0, st);
    send_beat(8'h10, 1'b0, st);
    s_valid = 1'b1;
    s_data  = 8'h00;
    s_last  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stall: s_ready=%b, required 0", s_ready); end
    @(posedge clk);
    #1;
    n_checks++;
    if (m_data !== 6'b100100) begin n_fail++; $display("[TB] FAIL bp_hold: m_data=%b, required 100100", m_data); end
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_valid: m_valid=%b, required 1", m_valid); end
    m_ready = 1'b1;
    send_beat(8'h00, 1'b1, st);
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_swap_valid: m_valid=%b, required 1", m_valid); end
    n_checks++;
    if (m_data !== 6'b000111) begin n_fail++; $display("[TB] FAIL bp_swap_data: m_data=%b, required 000111", m_data); end
    idle(2);
  endtask

  task automatic test_short_sample();
    int st;
    int e0;
    int o0;
    m_ready = 1'b1;
    e0 = err_seen;
    o0 = out_seen;
    send_beat(8'h10, 1'b0, st);
    send_beat(8'h10, 1'b1, st);
    idle(1);
    n_checks++;
    if (err_seen - e0 !== 1) begin n_fail++; $display("[TB] FAIL short_err: pulses=%0d, required 1", err_seen - e0); end
    n_checks++;
    if (out_seen - o0 !== 0) begin n_fail++; $display("[TB] FAIL short_no_out: samples=%0d, required 0", out_seen - o0); end
    send_beat(8'h00, 1'b0, st);
    send_beat(8'h10, 1'b0, st);
    send_beat(8'hE0, 1'b1, st);
    idle(1);
    n_checks++;
    if (out_seen - o0 !== 1) begin n_fail++; $display("[TB] FAIL short_then_full: samples=%0d, required 1", out_seen - o0); end
    n_checks++;
    if (err_seen - e0 !== 1) begin n_fail++; $display("[TB] FAIL short_err_total: pulses=%0d, required 1", err_seen - e0); end
  endtask

  task automatic test_long_sample();
    int st;
    int e0;
    int o0;
    m_ready = 1'b1;
    e0 = err_seen;
    o0 = out_seen;
    send_beat(8'h10, 1'b0, st);
    send_beat(8'h10, 1'b0, st);
    send_beat(8'h10, 1'b0, st);
    n_checks++;
    if (err_len !== 1'b1) begin n_fail++; $display("[TB] FAIL long_err: err_len=%b, required 1", err_len); end
    n_checks++;
    if (m_data !== 6'b010101) begin n_fail++; $display("[TB] FAIL long_data: m_data=%b, required 010101", m_data); end
    send_beat(8'hF0, 1'b0, st);
    send_beat(8'hF0, 1'b0, st);
    send_beat(8'hF0, 1'b1, st);
    idle(1);
    n_checks++;
    if (out_seen - o0 !== 2) begin n_fail++; $display("[TB] FAIL long_samples: samples=%0d, required 2", out_seen - o0); end
    n_checks++;
    if (err_seen - e0 !== 1) begin n_fail++; $display("[TB] FAIL long_err_total: pulses=%0d, required 1", err_seen - e0); end
  endtask

  task automatic test_reset_mid();
    int st;
    int o0;
    m_ready = 1'b1;
    send_beat(8'h7F, 1'b0, st);
    send_beat(8'h7F, 1'b0, st);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_s_ready: got %b, required 0", s_ready); end
    @(posedge clk);
    #1;
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_valid: got %b, required 0", m_valid); end
    n_checks++;
    if (m_data !== 6'b000000) begin n_fail++; $display("[TB] FAIL mid_reset_data: got %b, required 000000", m_data); end
    rst_n = 1'b1;
    model_reset();
    o0 = out_seen;
    send_beat(8'hE0, 1'b0, st);
    send_beat(8'hE0, 1'b0, st);
    send_beat(8'h10, 1'b1, st);
    n_checks++;
    if (m_data !== 6'b011010) begin n_fail++; $display("[TB] FAIL mid_reset_sample: m_data=%b, required 011010", m_data); end
    idle(1);
    n_checks++;
    if (out_seen - o0 !== 1) begin n_fail++; $display("[TB] FAIL mid_reset_count: samples=%0d, required 1", out_seen - o0); end
  endtask

  task automatic test_back_to_back();
    int st;
    int total_stalls;
    int o0;
    logic [7:0] d;
    logic want;
    m_ready = 1'b1;
    total_stalls = 0;
    o0 = out_seen;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      send_beat(d, (i % 3) == 2, st);
      total_stalls += st;
      want = ((i % 3) == 2);
      n_checks++;
      if (m_valid !== want) begin n_fail++; $display("[TB] FAIL stream_valid_%0d: m_valid=%b, required %b", i, m_valid, want); end
    end
    idle(1);
    n_checks++;
    if (total_stalls !== 0) begin n_fail++; $display("[TB] FAIL stream_stalls: stalls=%0d, required 0", total_stalls); end
    n_checks++;
    if (out_seen - o0 !== 4) begin n_fail++; $display("[TB] FAIL stream_samples: samples=%0d, required 4", out_seen - o0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_short_sample();
    test_long_sample();
    test_reset_mid();
    test_back_to_back();
    idle(2);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size()); end
    n_checks++;
    if (err_seen !== exp_err) begin n_fail++; $display("[TB] FAIL err_total: pulses=%0d, required %0d", err_seen, exp_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer0_input_packer.md
# layer0_input_packer

Front-end stage of the quantized LUT network. It accepts raw fixed-point input features one per beat over a valid/ready stream and quantizes each to `Q_BITS` with saturation. It assembles a full sample of `NUM_FEAT` features into one packed vector, which it holds in a registered output for the layer-0 neuron LUTs. Backpressure from the network side stalls the feature stream without losing data.

## Interface
Parameters:
- `NUM_FEAT`, default 16: features per sample (≥2).
- `IN_W`, default 16: width of the signed raw input feature.
- `Q_BITS`, default 2: width of each quantized feature (≥1, < `IN_W`).
- `SHIFT`, default 8: arithmetic right shift applied before saturation (1 ≤ `SHIFT` < `IN_W`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `s_valid` in 1: input feature valid.
- `s_ready` out 1: packer accepts a feature this cycle.
- `s_data` in `IN_W`: signed two's-complement feature.
- `s_last` in 1: marks the final feature of a sample.
- `m_valid` out 1: packed sample valid.
- `m_ready` in 1: downstream consumes the sample.
- `m_data` out `NUM_FEAT*Q_BITS`: packed sample; feature k is at `m_data[k*Q_BITS +: Q_BITS]`.
- `err_len` out 1: one-cycle pulse on a sample-length violation.

## Operation
- Quantize each feature as q = sat(s_data >>> `SHIFT`) to the signed range [-2^(Q_BITS-1), 2^(Q_BITS-1)-1], emitted as two's complement.
- Index counter `idx` runs 0..`NUM_FEAT`-1. There are two implicit states:
  - FILL (`idx` < `NUM_FEAT`-1): `s_ready`=1. An accepted beat writes q into assembly slot `idx` and increments `idx`.
  - LAST (`idx` = `NUM_FEAT`-1): `s_ready` = !`m_valid` | `m_ready`.
    - An accepted beat loads `m_data` with {q, assembly slots} and sets `m_valid`=1.
    - It then sets `idx`=0.
- Output register:
  - `m_valid` clears on `m_ready`, unless the register is reloaded in the same cycle. A simultaneous load and consume leaves `m_valid`=1 with the new data.
  - `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- Length checking:
  - `s_last`=1 accepted in FILL (short sample): the partial sample is discarded, `idx`=0, `err_len` pulses, and there is no output.
  - `s_last`=0 accepted in LAST (long sample): the sample is still emitted normally and `err_len` pulses. The following beats start a new sample.
- Reset:
  - Clears `idx` and the assembly slots to 0.
  - Sets `m_valid`=0, `m_data`=0 and `err_len`=0.
  - Holds `s_ready`=0 while `rst_n`=0.
  - Reset mid-sample discards the partial sample.

## Timing
- Latency: the final beat accepted at edge t gives `m_valid`=1 after edge t.
- Throughput: one feature per cycle sustained with `m_ready`=1, and one sample every `NUM_FEAT` cycles with no bubbles.
- `s_ready` has a combinational path from `m_ready` in LAST only. `m_valid`, `m_data` and `err_len` are registered outputs.
- `s_data` and `s_last` are sampled only when `s_valid` and `s_ready` are both 1.

## Configuration
- `LAYER0_PACK_ROUND_EN` defined:
  - Round half up before the shift: q = sat((s_data + 2^(SHIFT-1)) >>> SHIFT).
  - The addition is computed at `IN_W`+1 bits so it cannot wrap.
- Undefined: truncation (floor) as described above; no adder is instantiated.

## Test plan
Bench parameters: `NUM_FEAT`=3, `IN_W`=8, `Q_BITS`=2, `SHIFT`=4.

- Basic pack, truncation:
  - Stimulus: 0x10, 0xE0, 0x7F (last), with `m_ready`=1.
  - Required: `m_data`=6'b011001 and `m_valid` for one cycle, one cycle after the third beat.
- Rounding:
  - Stimulus: 0x08, 0x08, 0x08.
  - Required: `m_data`=6'b000000 without the macro and 6'b010101 with `LAYER0_PACK_ROUND_EN`.
- Backpressure:
  - Stimulus: hold `m_ready`=0 after sample A; stream sample B.
  - Required: `s_ready`=0 when B reaches `idx`=2, and `m_data` holds A.
  - Then raise `m_ready` for one cycle: A is consumed and B loads on the same edge, with `m_valid` remaining 1.
- Short sample:
  - Stimulus: 2 beats with `s_last` on beat 2, then 3 valid beats.
  - Required: `err_len` pulses once, with no output for the short sample, and exactly one `m_valid` for the 3-beat sample.
- Reset mid-sample:
  - Stimulus: 2 beats, then `rst_n`=0 for 1 cycle.
  - Required: `m_valid`=0 and `m_data`=0, and the next 3 beats produce exactly one sample containing only those 3 features.
- Streaming:
  - Stimulus: 12 back-to-back beats with correct `s_last` and `m_ready`=1.
  - Required: 4 samples, `m_valid` every third cycle, `s_ready` always 1.
